// File: rtl/spi_frame_scheduler.sv
// spi_frame_scheduler
//   Buffers 16-bit DSP samples in a FIFO and sends them to a single-byte SPI
//   master as fixed-length frames: header byte, each sample MSB then LSB, and
//   an XOR checksum of every preceding byte. An idle gap comes before each
//   byte so the slave sees a separate CS transaction per byte.
// Ports
//   i_Clk, i_Rst_L           clock, synchronous active-low reset
//   i_Sample, i_Sample_Valid sample input; accepted when valid && o_Sample_Ready
//   o_Sample_Ready           FIFO not full
//   o_TX_Byte, o_TX_DV       byte to the SPI master, one-cycle latch pulse
//   i_TX_Ready               SPI master idle
//   o_Frame_Done             one-cycle pulse after the checksum byte completes
//   o_Busy                   FSM is not idle
module spi_frame_scheduler #(
    parameter int unsigned SAMPLES_PER_FRAME = 4,
    parameter int unsigned FIFO_DEPTH        = 8,
    parameter int unsigned GAP_CYCLES        = 2000,
    parameter logic [7:0]  HEADER_BYTE       = 8'hA5
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [15:0] i_Sample,
    input  logic        i_Sample_Valid,
    output logic        o_Sample_Ready,
    output logic [7:0]  o_TX_Byte,
    output logic        o_TX_DV,
    input  logic        i_TX_Ready,
    output logic        o_Frame_Done,
    output logic        o_Busy
);

    localparam int unsigned FRAME_LEN = 2 + 2 * SAMPLES_PER_FRAME;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int unsigned GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(SAMPLES_PER_FRAME);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(FRAME_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_GAP, S_LOAD, S_PULSE, S_HOLD, S_WAIT_RDY, S_DONE
    } state_e;

    // Entry state for each byte: the gap, or straight to LOAD when there is none.
    localparam state_e S_BYTE_START = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

    state_e            state_q, state_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_dv_q, tx_dv_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              push, pop, byte_is_lsb;
    logic [15:0]       head;
    logic [7:0]        cur_byte;

    assign o_Sample_Ready = (count_q != CNT_FULL);
    assign o_TX_Byte      = tx_byte_q;
    assign o_TX_DV        = tx_dv_q;
    assign o_Frame_Done   = done_q;
    assign o_Busy         = busy_q;

    assign head        = mem_q[rd_ptr_q];
    assign byte_is_lsb = (idx_q != '0) && (idx_q != IDX_LAST) && !idx_q[0];
    assign push        = i_Sample_Valid && o_Sample_Ready;
    // The sample at the FIFO head is the one being sent, so it leaves with its LSB.
    assign pop         = (state_q == S_PULSE) && byte_is_lsb;

    always_comb begin
        cur_byte = head[7:0];
        if (idx_q == '0) begin
            cur_byte = HEADER_BYTE;
        end else if (idx_q == IDX_LAST) begin
            cur_byte = chk_q;
        end else if (idx_q[0]) begin
            cur_byte = head[15:8];
        end
    end

    // Sample FIFO
    always_ff @(posedge i_Clk) begin
        if (i_Rst_L && push) begin
            mem_q[wr_ptr_q] <= i_Sample;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Frame sequencer
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            gap_q     <= '0;
            chk_q     <= '0;
            tx_byte_q <= '0;
            tx_dv_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            chk_q     <= chk_d;
            tx_byte_q <= tx_byte_d;
            tx_dv_q   <= tx_dv_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        chk_d     = chk_q;
        tx_byte_d = tx_byte_q;
        tx_dv_d   = 1'b0;
        done_d    = 1'b0;
        busy_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                chk_d = '0;
                gap_d = '0;
                if (count_q >= CNT_FRAME) begin
                    state_d = S_BYTE_START;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_LOAD: begin
                if (i_TX_Ready) begin
                    tx_dv_d = 1'b1;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                chk_d   = chk_q ^ tx_byte_q;
                idx_d   = idx_q + IDX_W'(1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (i_TX_Ready) begin
                    if (idx_q < IDX_END) begin
                        state_d = S_BYTE_START;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Clear here too so IDLE can start the next frame on its first cycle.
                idx_d   = '0;
                chk_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Byte is captured on LOAD entry and held through PULSE.
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            tx_byte_d = cur_byte;
        end
        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_spi_frame_scheduler.sv
module tb_spi_frame_scheduler;

    localparam int GA    = 16;
    localparam int GB    = 2000;
    localparam int FLEN  = 10;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] a_sample, b_sample;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [7:0]  a_byte, b_byte;
    logic        a_dv, b_dv;
    logic        a_txrdy, b_txrdy;
    logic        a_done, b_done;
    logic        a_busy, b_busy;

    always #5 clk = ~clk;

    spi_frame_scheduler #(
        .SAMPLES_PER_FRAME(4), .FIFO_DEPTH(8), .GAP_CYCLES(GA), .HEADER_BYTE(8'hA5)
    ) dut_a (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Sample(a_sample), .i_Sample_Valid(a_valid),
        .o_Sample_Ready(a_ready), .o_TX_Byte(a_byte), .o_TX_DV(a_dv),
        .i_TX_Ready(a_txrdy), .o_Frame_Done(a_done), .o_Busy(a_busy)
    );

    spi_frame_scheduler #(
        .GAP_CYCLES(GB)
    ) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Sample(b_sample), .i_Sample_Valid(b_valid),
        .o_Sample_Ready(b_ready), .o_TX_Byte(b_byte), .o_TX_DV(b_dv),
        .i_TX_Ready(b_txrdy), .o_Frame_Done(b_done), .o_Busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model for dut_a: sample queue in arrival order, occupancy, frame position.
    logic [15:0] mq[$];
    int          mcount   = 0;
    int          bpos     = 0;
    bit          pop_pend = 1'b0;
    logic [7:0]  exp_frame [FLEN];
    int          last_dv  = 0;
    int          dv_cnt   = 0;
    int          done_cnt = 0;

    logic [7:0]  b_bytes[$];
    int          b_times[$];
    int          b_done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void build_frame();
        logic [7:0]  x;
        logic [15:0] s;
        x = 8'hA5;
        exp_frame[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            s = (k < mq.size()) ? mq[k] : 16'hxxxx;
            exp_frame[2*k+1] = s[15:8];
            exp_frame[2*k+2] = s[7:0];
            x = x ^ s[15:8] ^ s[7:0];
        end
        exp_frame[FLEN-1] = x;
    endfunction

    // Advance one clock; inputs were set by the caller before the posedge.
    task automatic tick();
        bit push_now, pop_now;
        push_now = a_valid && rst_l && (mcount != 8);
        pop_now  = pop_pend;
        @(negedge clk);
        cyc++;
        if (!rst_l) begin
            mq.delete();
            mcount   = 0;
            bpos     = 0;
            pop_pend = 1'b0;
        end else begin
            if (push_now) mq.push_back(a_sample);
            mcount   = mcount + int'(push_now) - int'(pop_now);
            pop_pend = 1'b0;
            if (a_dv) begin
                if (bpos == 0) begin
                    chk("a_frame_resident", mq.size() >= 4, 1);
                    build_frame();
                end else begin
                    chk("a_dv_spacing", cyc - last_dv, GA + 4);
                end
                chk("a_byte", a_byte, (bpos < FLEN) ? exp_frame[bpos] : 8'hxx);
                last_dv  = cyc;
                dv_cnt++;
                pop_pend = (bpos > 0) && (bpos < FLEN - 1) && (bpos % 2 == 0);
                bpos++;
            end
            if (a_done) begin
                done_cnt++;
                chk("a_done_after_last_byte", bpos, FLEN);
                for (int k = 0; k < 4 && mq.size() > 0; k++) void'(mq.pop_front());
                bpos = 0;
            end
        end
        if (b_dv) begin
            b_bytes.push_back(b_byte);
            b_times.push_back(cyc);
        end
        if (b_done) b_done_cnt++;
    endtask

    task automatic push_a(input logic [15:0] s);
        a_sample = s;
        a_valid  = 1'b1;
        chk("a_ready_at_push", a_ready, mcount != 8);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_cnt;
        n     = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk("a_frame_completes", done_cnt - start, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dv"},    a_dv,    0);
        chk({tag, "_byte"},  a_byte,  0);
        chk({tag, "_done"},  a_done,  0);
        chk({tag, "_busy"},  a_busy,  0);
        chk({tag, "_ready"}, a_ready, 1);
    endtask

    initial begin
        int          d0, n, start;
        logic [15:0] bs [4];
        logic [7:0]  bx;
        logic [7:0]  bexp [FLEN];

        rst_l    = 1'b0;
        a_valid  = 1'b1;   // pushes during reset must be ignored
        a_sample = 16'hFFFF;
        b_valid  = 1'b0;
        b_sample = 16'h0;
        a_txrdy  = 1'b1;
        b_txrdy  = 1'b1;
        repeat (3) tick();
        a_valid = 1'b0;
        check_reset_outputs("reset");
        chk("reset_b_busy", b_busy, 0);
        rst_l = 1'b1;
        tick();
        chk("after_reset_ready", a_ready, 1);

        // Directed frame with known samples
        push_a(16'h1234);
        push_a(16'h5678);
        push_a(16'h9ABC);
        push_a(16'hDEF0);
        d0 = dv_cnt;
        wait_done(500);
        chk("t1_dv_count", dv_cnt - d0, FLEN);
        chk("t1_checksum_A5", exp_frame[FLEN-1], 8'hA5);
        tick();
        chk("t1_idle_busy", a_busy, 0);

        // Long gap on the default-parameter instance
        for (int i = 0; i < 4; i++) begin
            bs[i]    = 16'($urandom);
            b_sample = bs[i];
            b_valid  = 1'b1;
            tick();
        end
        b_valid = 1'b0;
        n = 0;
        while (b_done_cnt == 0 && n < 25000) begin
            tick();
            n++;
        end
        chk("t4_b_done", b_done_cnt, 1);
        bx = 8'hA5;
        bexp[0] = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            bexp[2*k+1] = bs[k][15:8];
            bexp[2*k+2] = bs[k][7:0];
            bx = bx ^ bs[k][15:8] ^ bs[k][7:0];
        end
        bexp[FLEN-1] = bx;
        chk("t4_b_byte_count", b_bytes.size(), FLEN);
        for (int i = 0; i < FLEN && i < b_bytes.size(); i++) begin
            chk("t4_b_byte", b_bytes[i], bexp[i]);
            if (i > 0) chk("t4_b_dv_spacing", b_times[i] - b_times[i-1], GB + 4);
        end
        tick();
        chk("t4_b_idle_busy", b_busy, 0);

        // Partial frame must not start
        for (int i = 0; i < 3; i++) push_a(16'($urandom));
        d0 = dv_cnt;
        repeat (10000) tick();
        chk("t2_no_dv", dv_cnt - d0, 0);
        chk("t2_idle_busy", a_busy, 0);
        push_a(16'($urandom));
        wait_done(500);

        // Master never ready: FIFO fills, frame parks on its header byte
        a_txrdy = 1'b0;
        for (int i = 0; i < 9; i++) push_a(16'($urandom));
        chk("t3_full_ready", a_ready, 0);
        d0 = dv_cnt;
        repeat (60) tick();
        chk("t3_no_dv", dv_cnt - d0, 0);
        chk("t3_busy", a_busy, 1);
        chk("t3_parked_byte", a_byte, 8'hA5);
        a_txrdy = 1'b1;
        wait_done(500);
        wait_done(500);
        tick();
        chk("t3_drained_ready", a_ready, 1);
        chk("t3_drained_busy", a_busy, 0);

        // Reset after the third byte of a frame
        for (int i = 0; i < 4; i++) push_a(16'($urandom));
        start = dv_cnt;
        n = 0;
        while (dv_cnt < start + 3 && n < 500) begin
            tick();
            n++;
        end
        chk("t5_three_bytes", dv_cnt - start, 3);
        rst_l = 1'b0;
        tick();
        check_reset_outputs("t5_reset");
        rst_l = 1'b1;
        for (int i = 0; i < 3; i++) push_a(16'($urandom));
        d0 = dv_cnt;
        repeat (200) tick();
        chk("t5_fifo_was_cleared", dv_cnt - d0, 0);
        push_a(16'($urandom));
        wait_done(500);

        // Full FIFO under continuous/random pushes while frames drain
        a_txrdy = 1'b0;
        for (int i = 0; i < 8; i++) push_a(16'($urandom));
        a_txrdy = 1'b1;
        start = done_cnt;
        a_sample = 16'($urandom);
        n = 0;
        while (done_cnt < start + 2 && n < 2000) begin
            bit acc;
            a_valid = ($urandom_range(3, 0) != 0);
            acc = a_valid && (mcount != 8);
            chk("t6_ready", a_ready, mcount != 8);
            tick();
            if (acc) a_sample = 16'($urandom);
            n++;
        end
        a_valid = 1'b0;
        chk("t6_two_frames", done_cnt - start, 2);
        n = 0;
        while (mcount >= 4 && n < 3) begin
            wait_done(1000);
            n++;
        end
        tick();
        chk("t6_ready_end", a_ready, mcount != 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
